// File: rtl/word_unpacker_if.sv
// Word-in / byte-out stream bundle for the word unpacker.
interface word_unpacker_if #(
    parameter int unsigned ERR_W = 8
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_byte;
    logic              out_last;
    logic              mismatch;
    logic [ERR_W-1:0]  err_count;

    // Producer of words / consumer of bytes.
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_byte, out_last, mismatch, err_count
    );

    // The unpacker itself.
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_byte, out_last, mismatch, err_count
    );
endinterface

// File: rtl/word_unpacker.sv
// Unpacks 16-bit words into a high-byte-first byte stream; optionally
// collapses duplicated-byte words {b,b} into a single byte.
module word_unpacker #(
    parameter bit          DEDUP = 1'b1,
    parameter int unsigned ERR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    word_unpacker_if.slave bus
);
    localparam int unsigned BYTE_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic [BYTE_W-1:0]  held_lo_q, held_lo_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;
    logic               mm_q, mm_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic               in_ready_c;
    logic               accept_c;
    logic [BYTE_W-1:0]  w_hi_c, w_lo_c;
    logic               dup_c;

    // Word halves and handshake decode.
    assign w_hi_c     = bus.in_word[15:8];
    assign w_lo_c     = bus.in_word[7:0];
    assign dup_c      = (w_hi_c == w_lo_c);
    assign in_ready_c = reset && ((state_q == IDLE) || ((state_q == LO) && bus.out_ready));
    assign accept_c   = bus.in_valid && in_ready_c;

    // Next state: drain current byte, then let a new accept overwrite the result.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        held_lo_d = held_lo_q;
        last_d    = last_q;
        mm_d      = 1'b0;
        err_d     = err_q;

        case (state_q)
            IDLE: ;
            HI: begin
                if (bus.out_ready) begin
                    state_d = LO;
                    byte_d  = held_lo_q;
                    last_d  = 1'b1;
                end
            end
            LO: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                last_d  = 1'b0;
            end
        endcase

        if (accept_c) begin
            held_lo_d = w_lo_c;
            byte_d    = w_hi_c;
            if (DEDUP && dup_c) begin
                state_d = LO;
                last_d  = 1'b1;
            end else begin
                state_d = HI;
                last_d  = 1'b0;
            end
            if (DEDUP && !dup_c) begin
                mm_d = 1'b1;
                if (err_q != ERR_MAX) begin
                    err_d = err_q + ERR_W'(1);
                end
            end
        end

        valid_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            held_lo_q <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            mm_q      <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            held_lo_q <= held_lo_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            mm_q      <= mm_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_byte  = byte_q;
    assign bus.out_last  = last_q;
    assign bus.mismatch  = mm_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_word_unpacker.sv
// Bench: two unpackers (dedup with 2-bit counter, plain with 8-bit counter)
// share one stimulus stream and are compared against a pending-byte model.
module tb_word_unpacker;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_word;
    logic        out_ready;

    word_unpacker_if #(.ERR_W(2)) ifa ();
    word_unpacker_if #(.ERR_W(8)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_word   = in_word;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_word   = in_word;
    assign ifb.out_ready = out_ready;

    word_unpacker #(.DEDUP(1'b1), .ERR_W(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    word_unpacker #(.DEDUP(1'b0), .ERR_W(8)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs of both DUTs gathered for indexed comparison.
    logic       a_valid [2];
    logic       a_ready [2];
    logic [7:0] a_byte  [2];
    logic       a_last  [2];
    logic       a_mm    [2];
    logic [7:0] a_err   [2];

    assign a_valid[0] = ifa.out_valid;
    assign a_ready[0] = ifa.in_ready;
    assign a_byte[0]  = ifa.out_byte;
    assign a_last[0]  = ifa.out_last;
    assign a_mm[0]    = ifa.mismatch;
    assign a_err[0]   = 8'(ifa.err_count);
    assign a_valid[1] = ifb.out_valid;
    assign a_ready[1] = ifb.in_ready;
    assign a_byte[1]  = ifb.out_byte;
    assign a_last[1]  = ifb.out_last;
    assign a_mm[1]    = ifb.mismatch;
    assign a_err[1]   = 8'(ifb.err_count);

    // Model: up to two pending {last,byte} entries, front entry is on the bus.
    typedef struct packed {
        logic [8:0] p0;
        logic [8:0] p1;
        logic [1:0] n;
        logic [7:0] ebyte;
        logic       emm;
        logic [7:0] ecnt;
    } model_t;

    model_t m [2];

    function automatic bit dedup_of(input int k);
        return (k == 0);
    endfunction

    function automatic int unsigned cmax_of(input int k);
        return (k == 0) ? 3 : 255;
    endfunction

    function automatic logic exp_rdy(input model_t s, input logic rst, input logic ordy);
        return rst && ((s.n == 2'd0) || ((s.n == 2'd1) && ordy));
    endfunction

    function automatic model_t step(input model_t s, input int k, input logic iv,
                                   input logic [15:0] w, input logic ordy);
        model_t r;
        logic acc;
        logic [7:0] hi, lo;
        r   = s;
        acc = iv && exp_rdy(s, 1'b1, ordy);
        hi  = w[15:8];
        lo  = w[7:0];
        r.emm = 1'b0;
        if (r.n != 2'd0 && ordy) begin
            r.p0 = r.p1;
            r.n  = r.n - 2'd1;
        end
        if (acc) begin
            // The pending list is always empty once an accept is allowed.
            if (dedup_of(k) && hi == lo) begin
                r.p0 = {1'b1, hi};
                r.n  = 2'd1;
            end else begin
                r.p0 = {1'b0, hi};
                r.p1 = {1'b1, lo};
                r.n  = 2'd2;
            end
            if (dedup_of(k) && hi != lo) begin
                r.emm = 1'b1;
                if (int'(r.ecnt) < int'(cmax_of(k))) r.ecnt = r.ecnt + 8'd1;
            end
        end
        if (r.n != 2'd0) r.ebyte = r.p0[7:0];
        return r;
    endfunction

    // Model update on every clock edge, cleared asynchronously by reset.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            for (int k = 0; k < 2; k++) begin
                if (!reset) m[k] <= '0;
                else        m[k] <= step(m[k], k, in_valid, in_word, out_ready);
            end
        end
    end

    int total;
    int bad;

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
        end
    endtask

    // Hand-computed expectations for dut_a, posted by the directed sequence.
    logic       lit_chk;
    logic       lv, ll, lm, lr;
    logic [7:0] lb;
    logic [7:0] le;

    // Single compare process: model check for both DUTs every cycle, plus literals.
    initial begin
        total = 0;
        bad   = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("out_valid", k, 16'(a_valid[k]), 16'(m[k].n != 2'd0));
                chk("in_ready",  k, 16'(a_ready[k]), 16'(exp_rdy(m[k], reset, out_ready)));
                chk("out_byte",  k, 16'(a_byte[k]),  16'(m[k].ebyte));
                if (m[k].n != 2'd0) chk("out_last", k, 16'(a_last[k]), 16'(m[k].p0[8]));
                chk("mismatch",  k, 16'(a_mm[k]),    16'(m[k].emm));
                chk("err_count", k, 16'(a_err[k]),   16'(m[k].ecnt));
            end
            if (lit_chk) begin
                chk("lit_valid", 0, 16'(a_valid[0]), 16'(lv));
                chk("lit_byte",  0, 16'(a_byte[0]),  16'(lb));
                if (lv) chk("lit_last", 0, 16'(a_last[0]), 16'(ll));
                chk("lit_mm",    0, 16'(a_mm[0]),    16'(lm));
                chk("lit_err",   0, 16'(a_err[0]),   16'(le));
                chk("lit_ready", 0, 16'(a_ready[0]), 16'(lr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input logic v, input logic [7:0] b, input logic l, input logic mm,
                       input logic [7:0] e, input logic r);
        lv = v; lb = b; ll = l; lm = mm; le = e; lr = r;
        lit_chk = 1'b1;
        @(negedge clk);
        #1;
        lit_chk = 1'b0;
    endtask

    int sat [6];

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        lit_chk   = 1'b0;
        lv = 1'b0; lb = 8'h00; ll = 1'b0; lm = 1'b0; le = 8'h00; lr = 1'b0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_word   = 16'h0000;
        out_ready = 1'b0;
        sat = '{1, 2, 3, 3, 3, 3};

        repeat (3) tick();
        lit(1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);

        // Duplicated word collapses to one byte.
        tick();
        reset = 1'b1;
        in_valid = 1'b1; in_word = 16'h7B7B; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lit(1'b1, 8'h7B, 1'b1, 1'b0, 8'd0, 1'b1);
        tick();
        lit(1'b0, 8'h7B, 1'b0, 1'b0, 8'd0, 1'b1);

        // Mismatched word gives two bytes and one error.
        in_valid = 1'b1; in_word = 16'h1234;
        tick();
        in_valid = 1'b0;
        lit(1'b1, 8'h12, 1'b0, 1'b1, 8'd1, 1'b0);
        tick();
        lit(1'b1, 8'h34, 1'b1, 1'b0, 8'd1, 1'b1);
        tick();
        lit(1'b0, 8'h34, 1'b0, 1'b0, 8'd1, 1'b1);

        // Back-to-back words without bubbles.
        in_valid = 1'b1; in_word = 16'hAABB;
        tick();
        in_word = 16'hCCCC;
        lit(1'b1, 8'hAA, 1'b0, 1'b1, 8'd2, 1'b0);
        tick();
        lit(1'b1, 8'hBB, 1'b1, 1'b0, 8'd2, 1'b1);
        tick();
        in_word = 16'h0102;
        lit(1'b1, 8'hCC, 1'b1, 1'b0, 8'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        lit(1'b1, 8'h01, 1'b0, 1'b1, 8'd3, 1'b0);
        tick();
        lit(1'b1, 8'h02, 1'b1, 1'b0, 8'd3, 1'b1);
        tick();
        lit(1'b0, 8'h02, 1'b0, 1'b0, 8'd3, 1'b1);

        // Consumer stall holds the high byte.
        out_ready = 1'b0; in_valid = 1'b1; in_word = 16'hAABB;
        tick();
        in_valid = 1'b0;
        lit(1'b1, 8'hAA, 1'b0, 1'b1, 8'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            lit(1'b1, 8'hAA, 1'b0, 1'b0, 8'd3, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        lit(1'b1, 8'hBB, 1'b1, 1'b0, 8'd3, 1'b1);
        tick();
        lit(1'b0, 8'hBB, 1'b0, 1'b0, 8'd3, 1'b1);

        // Saturating 2-bit error counter.
        reset = 1'b0;
        lit(1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_word  = {8'h10 + 8'(i), 8'h80 + 8'(i)};
            tick();
            lit(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1, 8'(sat[i]), 1'b0);
            tick();
            lit(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 8'(sat[i]), 1'b1);
        end
        in_valid = 1'b0;
        tick();

        // Reset while presenting the high byte drops the word.
        out_ready = 1'b0; in_valid = 1'b1; in_word = 16'h5566;
        tick();
        in_valid = 1'b0;
        lit(1'b1, 8'h55, 1'b0, 1'b1, 8'd3, 1'b0);
        tick();
        reset = 1'b0;
        lit(1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_word = 16'h0909;
        tick();
        in_valid = 1'b0;
        lit(1'b1, 8'h09, 1'b1, 1'b0, 8'd0, 1'b1);
        tick();
        lit(1'b0, 8'h09, 1'b0, 1'b0, 8'd0, 1'b1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_word[15:8] = 8'($urandom);
            in_word[7:0]  = ($urandom_range(0, 2) == 0) ? in_word[15:8] : 8'($urandom);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
